// File: rtl/axi_lite_cfg_seq.sv
// axi_lite_cfg_seq: AXI4-Lite configuration master. It executes WRITE / READ / POLL
// commands taken from a ready/valid command port and returns one response per command.
// The macro AXI_CFG_TIMEOUT_EN enables a per-handshake watchdog (rsp_err = 3).
// Without the macro the block waits on the slave indefinitely.
module axi_lite_cfg_seq #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_POLL = 256,
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  // command / response ports
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W-1:0]   cmd_mask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_err,
  output logic                busy,
  // AXI4-Lite read channels
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY,
  // AXI4-Lite write channels
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PCNT_W = $clog2(MAX_POLL + 1);
  localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd2;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_BUS  = 2'd1;
  localparam logic [1:0] ERR_EXH  = 2'd2;

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, GAP, RSP} state_t;

  state_t              state;
  logic                is_poll;
  logic [DATA_W-1:0]   poll_data;
  logic [DATA_W-1:0]   poll_mask;
  logic                aw_done;
  logic                w_done;
  logic [PCNT_W-1:0]   poll_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  logic                aw_hs;
  logic                w_hs;
  logic                poll_match;
  logic                poll_last;
  logic [PCNT_W-1:0]   poll_cnt_nxt;

  assign aw_hs        = AWVALID && AWREADY;
  assign w_hs         = WVALID && WREADY;
  assign poll_match   = ((RDATA ^ poll_data) & poll_mask) == '0;
  assign poll_cnt_nxt = poll_cnt + PCNT_W'(1);
  assign poll_last    = poll_cnt_nxt == PCNT_W'(MAX_POLL);

`ifdef AXI_CFG_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0]  ERR_WD = 2'd3;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;
  logic            any_hs;
  logic            wd_hit;

  assign wd_active = state inside {WR, WR_B, RD_A, RD_R};
  assign any_hs    = aw_hs || w_hs || (BREADY && BVALID) ||
                     (ARVALID && ARREADY) || (RREADY && RVALID);
  assign wd_hit    = wd_active && !any_hs && (wd_cnt == WD_W'(TIMEOUT - 1));

  // Watchdog: cycles since entering a waiting state or since the last handshake.
  always_ff @(posedge clk) begin
    if (reset || !wd_active || any_hs) wd_cnt <= '0;
    else                               wd_cnt <= wd_cnt + WD_W'(1);
  end
`endif

  // Command sequencer: state, AXI channel controls and the response register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
      busy      <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WSTRB     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      is_poll   <= 1'b0;
      poll_data <= '0;
      poll_mask <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            is_poll   <= cmd_op == OP_POLL;
            poll_data <= cmd_data;
            poll_mask <= cmd_mask;
            poll_cnt  <= '0;
            if (cmd_op == OP_WRITE) begin
              state   <= WR;
              AWADDR  <= cmd_addr;
              WDATA   <= cmd_data;
              WSTRB   <= cmd_mask[STRB_W-1:0];
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= RD_A;
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
            end
          end
        end

        WR: begin
          if (aw_hs) AWVALID <= 1'b0;
          if (w_hs)  WVALID  <= 1'b0;
          aw_done <= aw_done || aw_hs;
          w_done  <= w_done || w_hs;
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state  <= WR_B;
            BREADY <= 1'b1;
          end
        end

        WR_B: begin
          if (BVALID) begin
            BREADY    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= (BRESP != 2'b00) ? ERR_BUS : ERR_OK;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RD_A: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_R;
          end
        end

        RD_R: begin
          if (RVALID) begin
            RREADY   <= 1'b0;
            rsp_data <= RDATA;
            poll_cnt <= poll_cnt_nxt;
            // bus error wins over a match or exhaustion on the same read
            if (RRESP != 2'b00) begin
              rsp_err   <= ERR_BUS;
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else if (!is_poll || poll_match) begin
              rsp_err   <= ERR_OK;
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else if (poll_last) begin
              rsp_err   <= ERR_EXH;
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else if (POLL_GAP == 0) begin
              ARVALID <= 1'b1;
              state   <= RD_A;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
            ARVALID <= 1'b1;
            state   <= RD_A;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

`ifdef AXI_CFG_TIMEOUT_EN
      // A stalled handshake abandons the transfer and reports a watchdog error.
      if (wd_hit) begin
        AWVALID   <= 1'b0;
        WVALID    <= 1'b0;
        BREADY    <= 1'b0;
        ARVALID   <= 1'b0;
        RREADY    <= 1'b0;
        rsp_data  <= '0;
        rsp_err   <= ERR_WD;
        rsp_valid <= 1'b1;
        state     <= RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_cfg_seq.sv
// tb_axi_lite_cfg_seq: directed and randomized checks of axi_lite_cfg_seq against a
// command-level reference model and a configurable AXI4-Lite slave.
`timescale 1ns/1ps
module tb_axi_lite_cfg_seq;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_POLL = 4;
  localparam int unsigned POLL_GAP = 3;
  localparam int unsigned TIMEOUT  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [31:0] cmd_mask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic [1:0]  BRESP = '0;
  logic        BVALID = 1'b0;
  logic        BREADY;

  int vectors = 0;
  int miscompares = 0;

  // slave configuration (written by the stimulus only)
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit          aw_stuck = 0, w_stuck = 0;
  logic [1:0]  bresp_cfg = '0;
  logic [31:0] rd_arr [0:7];
  logic [1:0]  rr_arr [0:7];

  // slave observations (written by the slave only)
  int          scyc = 0;
  int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;
  int          awv_cyc = 0, wv_cyc = 0;
  bit          w_unstable = 0, w_seen = 0;
  logic [31:0] w_first = '0;
  int          aw_fire_cyc = 0, w_fire_cyc = 0, r_fire_cyc = 0;
  int          gap_min = 0, gap_max = 0;
  bit          have_r = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  bit          aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0;
  bit          aw_done = 0, w_done = 0, r_pend = 0, busy_q = 0, arv_q = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rd_idx = 0;

  axi_lite_cfg_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_POLL(MAX_POLL),
    .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "bench stalled");
  end

  // AXI4-Lite slave: decides READY/VALID on the falling edge for the next rising edge.
  always @(negedge clk) begin
    scyc++;
    if (reset) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
      aw_done = 0; w_done = 0; r_pend = 0; busy_q = 0; arv_q = 0; w_seen = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      // retire the handshakes that completed on the previous rising edge
      if (aw_fire) begin AWREADY = 0; aw_fire = 0; aw_done = 1; end
      if (w_fire)  begin WREADY = 0;  w_fire = 0;  w_done = 1;  end
      if (b_fire)  begin BVALID = 0;  b_fire = 0; end
      if (ar_fire) begin ARREADY = 0; ar_fire = 0; r_pend = 1; end
      if (r_fire)  begin RVALID = 0;  r_fire = 0; end
      // per-command statistics restart when the master turns busy
      if (busy && !busy_q) begin
        awv_cyc = 0; wv_cyc = 0; w_unstable = 0; have_r = 0;
        gap_min = 1 << 30; gap_max = -1; rd_idx = 0;
      end
      busy_q = busy;
      // write address
      if (AWVALID) awv_cyc++;
      if (AWVALID && !AWREADY) begin
        if (!aw_stuck && aw_cnt >= aw_dly) begin
          AWREADY = 1; aw_fire = 1; aw_hs_n++; cap_awaddr = AWADDR;
          aw_fire_cyc = scyc; aw_cnt = 0;
        end else aw_cnt++;
      end else if (!AWVALID) aw_cnt = 0;
      // write data
      if (WVALID) begin
        wv_cyc++;
        if (!w_seen) begin w_seen = 1; w_first = WDATA; end
        else if (WDATA !== w_first) w_unstable = 1;
      end else w_seen = 0;
      if (WVALID && !WREADY) begin
        if (!w_stuck && w_cnt >= w_dly) begin
          WREADY = 1; w_fire = 1; w_hs_n++; cap_wdata = WDATA; cap_wstrb = WSTRB;
          w_fire_cyc = scyc; w_cnt = 0;
        end else w_cnt++;
      end else if (!WVALID) w_cnt = 0;
      // write response only after both write handshakes
      if (aw_done && w_done && !BVALID) begin
        if (b_cnt >= b_dly) begin
          BVALID = 1; BRESP = bresp_cfg; b_cnt = 0; aw_done = 0; w_done = 0;
        end else b_cnt++;
      end
      if (BVALID && BREADY && !b_fire) b_fire = 1;
      // read address, with gap measurement from the previous read data handshake
      if (ARVALID && !arv_q && have_r) begin
        if (scyc - r_fire_cyc - 1 < gap_min) gap_min = scyc - r_fire_cyc - 1;
        if (scyc - r_fire_cyc - 1 > gap_max) gap_max = scyc - r_fire_cyc - 1;
      end
      arv_q = ARVALID;
      if (ARVALID && !ARREADY) begin
        if (ar_cnt >= ar_dly) begin
          ARREADY = 1; ar_fire = 1; ar_hs_n++; ar_cnt = 0;
        end else ar_cnt++;
      end else if (!ARVALID) ar_cnt = 0;
      // read data from the per-command response table
      if (r_pend && !RVALID) begin
        if (r_cnt >= r_dly) begin
          RVALID = 1;
          RDATA  = (rd_idx < 8) ? rd_arr[rd_idx] : 32'h0;
          RRESP  = (rd_idx < 8) ? rr_arr[rd_idx] : 2'd0;
          rd_idx++; r_cnt = 0; r_pend = 0;
        end else r_cnt++;
      end
      if (RVALID && RREADY && !r_fire) begin
        r_fire = 1; r_fire_cyc = scyc; have_r = 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Command-level reference: what the response should be given the slave's answers.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] data,
                                    input logic [31:0] mask, input logic [1:0] bresp,
                                    output logic [31:0] e_data, output logic [1:0] e_err,
                                    output int e_reads);
    e_data = 0; e_err = 0; e_reads = 0;
    if (op == 2'd0) begin
      e_err = (bresp != 0) ? 2'd1 : 2'd0;
      return;
    end
    if (op != 2'd2) begin
      e_data = rd_arr[0]; e_err = (rr_arr[0] != 0) ? 2'd1 : 2'd0; e_reads = 1;
      return;
    end
    e_err = 2'd2;
    for (int i = 0; i < int'(MAX_POLL); i++) begin
      e_reads = i + 1;
      e_data  = rd_arr[i];
      if (rr_arr[i] != 0) begin e_err = 2'd1; return; end
      if ((rd_arr[i] & mask) == (data & mask)) begin e_err = 2'd0; return; end
    end
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, ".ctl"}, {56'h0, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, busy, cmd_ready},
          64'h01);
    check({tag, ".addr"}, {AWADDR, ARADDR}, 64'h0);
    check({tag, ".data"}, {WDATA, rsp_data}, 64'h0);
    check({tag, ".strb_err"}, {58'h0, WSTRB, rsp_err}, 64'h0);
  endtask

  // Issue one command, wait for its response, check it and consume it.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] mask,
                         input int exp_lat, input bit wd_case);
    logic [31:0] e_data, d0;
    logic [1:0]  e_err;
    int          e_reads, ar0, aw0, lat, hold;
    bit          got;
    ref_model(op, data, mask, bresp_cfg, e_data, e_err, e_reads);
    if (wd_case) begin e_data = 0; e_err = 2'd3; end
    ar0 = ar_hs_n; aw0 = aw_hs_n;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin got = 1; break; end
      @(negedge clk);
    end
    check({name, ".accept"}, 64'(got), 64'h1);
    got = 0; lat = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) begin
        cmd_valid = 0;
        check({name, ".busy_ready"}, {62'h0, busy, cmd_ready}, 64'h2);
      end
      if (rsp_valid) begin got = 1; break; end
    end
    cmd_valid = 0;
    check({name, ".rsp_seen"}, 64'(got), 64'h1);
    if (!got) return;
    if (exp_lat >= 0) check({name, ".latency"}, 64'(lat), 64'(exp_lat));
    check({name, ".rsp_data"}, 64'(rsp_data), 64'(e_data));
    check({name, ".rsp_err"}, 64'(rsp_err), 64'(e_err));
    check({name, ".ar_count"}, 64'(ar_hs_n - ar0), 64'(e_reads));
    check({name, ".aw_count"}, 64'(aw_hs_n - aw0), 64'((op == 2'd0 && !wd_case) ? 1 : 0));
    if (op == 2'd0 && !wd_case) begin
      check({name, ".awaddr"}, 64'(cap_awaddr), 64'(addr));
      check({name, ".wdata"}, 64'(cap_wdata), 64'(data));
      check({name, ".wstrb"}, 64'(cap_wstrb), 64'(mask[3:0]));
    end
    d0 = rsp_data;
    hold = $urandom_range(0, 2);
    repeat (hold) @(negedge clk);
    check({name, ".rsp_hold"}, {31'h0, rsp_valid, rsp_data}, {31'h0, 1'b1, d0});
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check({name, ".post_rsp"}, {61'h0, rsp_valid, cmd_ready, busy}, 64'h2);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 8; i++) begin rd_arr[i] = 0; rr_arr[i] = 0; end
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] data, mask;
    clear_tables();
    repeat (3) @(negedge clk);
    check_reset_state("reset_held");
    reset = 0;
    @(negedge clk);
    check_reset_state("reset_release");

    // zero-wait write: AW and W in the same cycle, 3-cycle latency
    run_cmd("wr_zero", 2'd0, 32'h40, 32'h1, 32'hF, 3, 0);
    check("wr_zero.aw_w_same_cycle", 64'(aw_fire_cyc - w_fire_cyc), 64'h0);
    check("wr_zero.awvalid_cycles", 64'(awv_cyc), 64'h1);

    // WREADY 5 cycles late: AWVALID 1 cycle, WVALID 6 cycles with stable WDATA
    w_dly = 5;
    run_cmd("wr_wdly", 2'd0, 32'h44, 32'hA5A5_0001, 32'h3, -1, 0);
    check("wr_wdly.awvalid_cycles", 64'(awv_cyc), 64'h1);
    check("wr_wdly.wvalid_cycles", 64'(wv_cyc), 64'h6);
    check("wr_wdly.wdata_stable", 64'(w_unstable), 64'h0);
    w_dly = 0;

    // READ with RVALID delayed
    r_dly = 4; rd_arr[0] = 32'h3;
    run_cmd("rd_slow", 2'd1, 32'h44, 32'h0, 32'h0, -1, 0);
    r_dly = 0;

    // POLL that matches on the third read
    clear_tables(); rd_arr[2] = 32'h2;
    run_cmd("poll_match", 2'd2, 32'h0, 32'h2, 32'h2, -1, 0);
    check("poll_match.gap_min", 64'(gap_min), 64'(POLL_GAP));
    check("poll_match.gap_max", 64'(gap_max), 64'(POLL_GAP));

    // POLL that never matches
    clear_tables();
    run_cmd("poll_exhaust", 2'd2, 32'h8, 32'h1, 32'h1, -1, 0);
    check("poll_exhaust.gap_min", 64'(gap_min), 64'(POLL_GAP));

    // READ with SLVERR
    clear_tables(); rd_arr[0] = 32'hDEAD_BEEF; rr_arr[0] = 2'd2;
    run_cmd("rd_err", 2'd1, 32'hC, 32'h0, 32'h0, -1, 0);

    // POLL where a bus error coincides with a matching value
    clear_tables(); rd_arr[1] = 32'h10; rr_arr[1] = 2'd2;
    run_cmd("poll_err_prio", 2'd2, 32'h4, 32'h10, 32'h10, -1, 0);

    // WRITE with error response, then reserved opcode behaving as READ
    bresp_cfg = 2'd2;
    run_cmd("wr_berr", 2'd0, 32'h48, 32'h1234_5678, 32'h5, -1, 0);
    bresp_cfg = 2'd0;
    clear_tables(); rd_arr[0] = 32'h0BAD_CAFE;
    run_cmd("rd_reserved", 2'd3, 32'h4C, 32'h0, 32'h0, -1, 0);

`ifdef AXI_CFG_TIMEOUT_EN
    // write stalls on both AW and W: watchdog ends it after TIMEOUT cycles
    aw_stuck = 1; w_stuck = 1;
    run_cmd("wd_write", 2'd0, 32'h40, 32'h5, 32'hF, -1, 1);
    check("wd_write.awvalid_cycles", 64'(awv_cyc), 64'(TIMEOUT));
    aw_stuck = 0; w_stuck = 0;
`endif

    // reset in the middle of a read
    clear_tables(); rd_arr[0] = 32'h77; r_dly = 20;
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'd1; cmd_addr = 32'h4C;
    @(negedge clk);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    check("rst_mid.rready", 64'(RREADY), 64'h1);
    reset = 1;
    @(negedge clk);
    check_reset_state("rst_mid");
    @(negedge clk);
    reset = 0; r_dly = 0;
    @(negedge clk);

    // randomized commands and slave timing
    for (int n = 0; n < 40; n++) begin
      op   = 2'($urandom_range(0, 3));
      data = $urandom;
      mask = $urandom;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      for (int i = 0; i < 8; i++) begin
        rd_arr[i] = ($urandom_range(0, 2) == 0) ? (($urandom & ~mask) | (data & mask)) : $urandom;
        rr_arr[i] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      end
      run_cmd($sformatf("rand%0d", n), op, $urandom, data, mask, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
